// File: rtl/valu_issue_ctrl_pkg.sv
// Shared encodings for the vector ALU issue controller: opcode, function
// codes, latency classes, FSM states, lane widths and the zero-lane helper.
package valu_issue_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b101010;

  localparam logic [5:0] VAND   = 6'b000001;
  localparam logic [5:0] VOR    = 6'b000010;
  localparam logic [5:0] VXOR   = 6'b000011;
  localparam logic [5:0] VNOT   = 6'b000100;
  localparam logic [5:0] VMOV   = 6'b000101;
  localparam logic [5:0] VADD   = 6'b000110;
  localparam logic [5:0] VSUB   = 6'b000111;
  localparam logic [5:0] VMULEU = 6'b001000;
  localparam logic [5:0] VMULOU = 6'b001001;
  localparam logic [5:0] VSLL   = 6'b001010;
  localparam logic [5:0] VSRL   = 6'b001011;
  localparam logic [5:0] VSRA   = 6'b001100;
  localparam logic [5:0] VRTTH  = 6'b001101;
  localparam logic [5:0] VDIV   = 6'b001110;
  localparam logic [5:0] VMOD   = 6'b001111;
  localparam logic [5:0] VSQEU  = 6'b010000;
  localparam logic [5:0] VSQOU  = 6'b010001;
  localparam logic [5:0] VSQRT  = 6'b010010;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  typedef enum logic [1:0] {
    CLS_SIMPLE,
    CLS_MUL,
    CLS_DIV,
    CLS_SQRT
  } lat_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESULT
  } state_t;

  // True when any lane of v (lane size selected by ww) is all zeros.
  function automatic logic any_zero_lane(input logic [63:0] v, input logic [1:0] ww);
    logic z;
    z = 1'b0;
    case (ww)
      WW_8:    for (int i = 0; i < 8; i++) if (v[i*8 +: 8] == 8'd0) z = 1'b1;
      WW_16:   for (int i = 0; i < 4; i++) if (v[i*16 +: 16] == 16'd0) z = 1'b1;
      WW_32:   for (int i = 0; i < 2; i++) if (v[i*32 +: 32] == 32'd0) z = 1'b1;
      default: z = (v == 64'd0);
    endcase
    return z;
  endfunction

endpackage

// File: rtl/valu_issue_ctrl_lat_decode.sv
// Combinational instruction classifier: legality, latency (minus one, so a
// 16-cycle class still fits the 4-bit counter) and divide-by-zero lane flag.
module valu_issue_ctrl_lat_decode
  import valu_issue_ctrl_pkg::*;
#(
  parameter int unsigned LAT_SIMPLE = 1,
  parameter int unsigned LAT_MUL    = 2,
  parameter int unsigned LAT_DIV    = 8,
  parameter int unsigned LAT_SQRT   = 8
) (
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [1:0]  ww,
  input  logic [63:0] rb,
  output logic        legal,
  output logic        div_zero,
  output logic [3:0]  lat_m1
);

  lat_class_t lat_class;

  // Classify the function code and derive the per-class latency.
  always_comb begin
    legal = (opcode == OPC_RTYPE) && (func != 6'd0) && (func <= VSQRT);
    case (func)
      VMULEU, VMULOU, VSQEU, VSQOU: lat_class = CLS_MUL;
      VDIV, VMOD:                   lat_class = CLS_DIV;
      VSQRT:                        lat_class = CLS_SQRT;
      default:                      lat_class = CLS_SIMPLE;
    endcase
    case (lat_class)
      CLS_MUL:  lat_m1 = 4'(LAT_MUL - 1);
      CLS_DIV:  lat_m1 = 4'(LAT_DIV - 1);
      CLS_SQRT: lat_m1 = 4'(LAT_SQRT - 1);
      default:  lat_m1 = 4'(LAT_SIMPLE - 1);
    endcase
    div_zero = (lat_class == CLS_DIV) && any_zero_lane(rb, ww);
  end

endmodule

// File: rtl/valu_issue_ctrl.sv
// Issue/sequencing controller for the 64-bit vector ALU. Holds one
// instruction's operands steady for its latency, captures the result and
// presents it to writeback; illegal instructions complete immediately.
//
// state     | meaning
// ST_IDLE   | nothing in flight, ready for decode
// ST_EXEC   | operands driven to ALU, counting down latency
// ST_RESULT | result held on out_* until writeback takes it
module valu_issue_ctrl
  import valu_issue_ctrl_pkg::*;
#(
  parameter int unsigned LAT_SIMPLE = 1,  // each LAT_* must be 1..16
  parameter int unsigned LAT_MUL    = 2,
  parameter int unsigned LAT_DIV    = 8,
  parameter int unsigned LAT_SQRT   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:5]  in_opcode,
  input  logic [0:5]  in_func,
  input  logic [0:1]  in_ww,
  input  logic [0:4]  in_rd,
  input  logic [0:63] in_rA,
  input  logic [0:63] in_rB,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_func,
  output logic [0:5]  alu_opcode,
  output logic [0:1]  alu_ww,
  input  logic [0:63] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_data,
  output logic [0:4]  out_rd,
  output logic        out_err,
  output logic        busy
);

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] rd_q;
  logic       div_zero_q;
  logic       legal;
  logic       div_zero;
  logic [3:0] lat_m1;
  logic       accept;

  valu_issue_ctrl_lat_decode #(
    .LAT_SIMPLE (LAT_SIMPLE),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV),
    .LAT_SQRT   (LAT_SQRT)
  ) u_lat_decode (
    .opcode   (in_opcode),
    .func     (in_func),
    .ww       (in_ww),
    .rb       (in_rB),
    .legal    (legal),
    .div_zero (div_zero),
    .lat_m1   (lat_m1)
  );

  // Accept when idle, or when the held result leaves this same cycle.
  always_comb begin
    in_ready = ~reset & ((state == ST_IDLE) | ((state == ST_RESULT) & out_ready));
    accept   = in_valid & in_ready & ~flush;
    busy     = (state != ST_IDLE);
  end

  // Issue FSM, latency counter, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rd_q       <= '0;
      div_zero_q <= 1'b0;
      alu_rA     <= '0;
      alu_rB     <= '0;
      alu_func   <= '0;
      alu_opcode <= '0;
      alu_ww     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
    end else if (flush) begin
      // alu_* deliberately kept so the ALU inputs do not glitch on abort
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      if (legal) begin
        alu_rA     <= in_rA;
        alu_rB     <= in_rB;
        alu_func   <= in_func;
        alu_opcode <= in_opcode;
        alu_ww     <= in_ww;
        rd_q       <= in_rd;
        div_zero_q <= div_zero;
        cnt        <= lat_m1;
        out_valid  <= 1'b0;
        out_err    <= 1'b0;
        state      <= ST_EXEC;
      end else begin
        // illegal ops bypass the ALU and report straight away
        out_valid <= 1'b1;
        out_data  <= '0;
        out_rd    <= in_rd;
        out_err   <= 1'b1;
        cnt       <= '0;
        state     <= ST_RESULT;
      end
    end else begin
      case (state)
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            out_data  <= alu_out;
            out_valid <= 1'b1;
            out_rd    <= rd_q;
            out_err   <= div_zero_q;
            state     <= ST_RESULT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Directed bench for valu_issue_ctrl with a behavioural ALU stub.
module tb_valu_issue_ctrl;
  import valu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_err, busy;
  logic [5:0]  in_opcode, in_func, alu_func, alu_opcode;
  logic [1:0]  in_ww, alu_ww;
  logic [4:0]  in_rd, out_rd;
  logic [63:0] in_rA, in_rB, alu_rA, alu_rB, alu_out, out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  valu_issue_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func(in_func), .in_ww(in_ww), .in_rd(in_rd),
    .in_rA(in_rA), .in_rB(in_rB),
    .alu_rA(alu_rA), .alu_rB(alu_rB), .alu_func(alu_func),
    .alu_opcode(alu_opcode), .alu_ww(alu_ww), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err), .busy(busy)
  );

  // ALU stub: a few real ops, everything else a ^ b.
  function automatic logic [63:0] alu_model(input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
    case (f)
      VAND:                         return a & b;
      VOR:                          return a | b;
      VADD:                         return a + b;
      VSUB:                         return a - b;
      VMULEU, VMULOU, VSQEU, VSQOU: return a * b;
      default:                      return a ^ b;
    endcase
  endfunction

  always_comb alu_out = alu_model(alu_func, alu_rA, alu_rB);

  typedef struct {
    logic [5:0]  opc;
    logic [5:0]  func;
    logic [1:0]  ww;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [5:0] opc, input logic [5:0] func, input logic [1:0] ww,
                              input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                              input int lat, input logic [63:0] data, input logic err);
    vec_t v;
    v.opc = opc; v.func = func; v.ww = ww; v.rd = rd; v.a = a; v.b = b;
    v.lat = lat; v.data = data; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] opc, input logic [5:0] func, input logic [1:0] ww,
                       input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
    in_opcode = opc; in_func = func; in_ww = ww; in_rd = rd; in_rA = a; in_rB = b;
  endtask

  initial begin
    logic [5:0]  exp_func;
    logic [63:0] exp_rA;
    int          cycles;

    vecs[0]  = mk(OPC_RTYPE, VADD,    WW_8,  5'd3,  64'd5, 64'd10, 1, 64'd15, 1'b0);
    vecs[1]  = mk(OPC_RTYPE, VMULEU,  WW_32, 5'd7,  64'd20, 64'd20, 2, 64'd400, 1'b0);
    vecs[2]  = mk(OPC_RTYPE, VDIV,    WW_8,  5'd1,  64'hFF00FF00_FF00FF00, 64'h11221122_44444444,
                  8, 64'hEE22EE22_BB44BB44, 1'b0);
    vecs[3]  = mk(OPC_RTYPE, VDIV,    WW_8,  5'd2,  64'hFF00FF00_FF00FF00, 64'h11001122_44444444,
                  8, 64'hEE00EE22_BB44BB44, 1'b1);
    vecs[4]  = mk(OPC_RTYPE, 6'b010011, WW_8, 5'd9, 64'd1, 64'd2, 0, 64'd0, 1'b1);
    vecs[5]  = mk(6'd0,      VADD,    WW_8,  5'd10, 64'd1, 64'd2, 0, 64'd0, 1'b1);
    vecs[6]  = mk(OPC_RTYPE, 6'd0,    WW_8,  5'd11, 64'd1, 64'd2, 0, 64'd0, 1'b1);
    vecs[7]  = mk(OPC_RTYPE, VSQRT,   WW_64, 5'd12, 64'h100, 64'h1, 8, 64'h101, 1'b0);
    vecs[8]  = mk(OPC_RTYPE, VMOD,    WW_16, 5'd13, 64'h0F, 64'h0001_0001_0000_0001,
                  8, 64'h0001_0001_0000_000E, 1'b1);
    vecs[9]  = mk(OPC_RTYPE, VSUB,    WW_64, 5'd14, 64'd100, 64'd1, 1, 64'd99, 1'b0);
    vecs[10] = mk(OPC_RTYPE, VSQEU,   WW_8,  5'd15, 64'd3, 64'd3, 2, 64'd9, 1'b0);
    vecs[11] = mk(OPC_RTYPE, VRTTH,   WW_8,  5'd16, 64'd6, 64'd3, 1, 64'd5, 1'b0);
    vecs[12] = mk(OPC_RTYPE, VDIV,    WW_64, 5'd31, 64'h1000, 64'h100, 8, 64'h1100, 1'b0);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(6'd0, 6'd0, 2'd0, 5'd0, 64'd0, 64'd0);
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_rA", alu_rA, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    exp_func = 6'd0;
    exp_rA   = 64'd0;

    // Table: each vector issued alone with writeback always ready.
    for (int i = 0; i < 13; i++) begin
      out_ready = 1'b1;
      drive(vecs[i].opc, vecs[i].func, vecs[i].ww, vecs[i].rd, vecs[i].a, vecs[i].b);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (vecs[i].lat > 0) begin
        check($sformatf("v%0d_in_ready_exec", i), 64'(in_ready), 64'd0);
        check($sformatf("v%0d_busy_exec", i), 64'(busy), 64'd1);
        exp_func = vecs[i].func;
        exp_rA   = vecs[i].a;
      end
      cycles = 0;
      while (!out_valid && cycles < 40) begin
        tick();
        cycles++;
      end
      check($sformatf("v%0d_latency", i), 64'(cycles), 64'(vecs[i].lat));
      check($sformatf("v%0d_data", i), out_data, vecs[i].data);
      check($sformatf("v%0d_err", i), 64'(out_err), 64'(vecs[i].err));
      check($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
      check($sformatf("v%0d_alu_func", i), 64'(alu_func), 64'(exp_func));
      check($sformatf("v%0d_alu_rA", i), alu_rA, exp_rA);
      if (vecs[i].lat > 0)
        check($sformatf("v%0d_alu_ww", i), 64'(alu_ww), 64'(vecs[i].ww));
      tick();
      check($sformatf("v%0d_done_valid", i), 64'(out_valid), 64'd0);
      check($sformatf("v%0d_done_busy", i), 64'(busy), 64'd0);
    end

    // Back-to-back VAND then VOR with writeback stalled for 3 cycles.
    out_ready = 1'b0;
    drive(OPC_RTYPE, VAND, WW_8, 5'd4, 64'd15, 64'd14);
    in_valid = 1'b1;
    tick();
    drive(OPC_RTYPE, VOR, WW_8, 5'd5, 64'd15, 64'd14);
    tick();
    check("b2b_first_valid", 64'(out_valid), 64'd1);
    check("b2b_first_data", out_data, 64'd14);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("b2b_hold%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("b2b_hold%0d_data", k), out_data, 64'd14);
      check($sformatf("b2b_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready_hs", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_hs_valid", 64'(out_valid), 64'd0);
    check("b2b_second_issued", 64'(alu_func), 64'(VOR));
    tick();
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_data", out_data, 64'd15);
    check("b2b_second_rd", 64'(out_rd), 64'd5);
    tick();

    // Illegal op accepted on the handshake edge of a legal result.
    drive(OPC_RTYPE, VADD, WW_8, 5'd6, 64'd1, 64'd1);
    in_valid = 1'b1;
    tick();
    drive(OPC_RTYPE, 6'b111111, WW_8, 5'd8, 64'd7, 64'd7);
    tick();
    check("ill_b2b_first_data", out_data, 64'd2);
    tick();
    in_valid = 1'b0;
    check("ill_b2b_valid", 64'(out_valid), 64'd1);
    check("ill_b2b_err", 64'(out_err), 64'd1);
    check("ill_b2b_data", out_data, 64'd0);
    check("ill_b2b_rd", 64'(out_rd), 64'd8);
    tick();

    // Flush a VSQRT at T+4 with another instruction on the input.
    drive(OPC_RTYPE, VSQRT, WW_64, 5'd20, 64'h55, 64'h3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    drive(OPC_RTYPE, VADD, WW_8, 5'd21, 64'd1, 64'd1);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_err", 64'(out_err), 64'd0);
    check("flush_alu_kept", 64'(alu_func), 64'(VSQRT));
    cycles = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) cycles++;
    end
    check("flush_never_valid", 64'(cycles), 64'd0);

    // Reset in the middle of a VSQRT.
    drive(OPC_RTYPE, VSQRT, WW_64, 5'd22, 64'h77, 64'h3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    check("rst_mid_alu_rA", alu_rA, 64'd0);
    check("rst_mid_alu_func", 64'(alu_func), 64'd0);
    check("rst_mid_out_data", out_data, 64'd0);
    check("rst_mid_out_rd", 64'(out_rd), 64'd0);
    tick();
    reset = 1'b0;
    cycles = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) cycles++;
    end
    check("rst_mid_never_valid", 64'(cycles), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
